// File: rtl/pwm_gen_multi.sv
// pwm_gen_multi
// Multi-channel PWM generator with press-duration duty control.
// A single press input is classified per press as short (duty up),
// long (duty down) or glitch (ignored), and the result is applied to the
// channel selected by sel. A shared prescaled period counter drives CH PWM
// outputs. Their duty codes are double-buffered and only take effect at
// period boundaries.
//
// Handshake/timing contract: start is a level input already synchronous to
// clk. A press is the run of consecutive cycles with start=1. It is evaluated
// on the first edge that samples start=0, using the sel value present at
// that edge.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-low reset
//   start     in   press input
//   sel       in   target channel, sampled at press evaluation
//   d_c       out  programmed duty codes, channel i at [i*DW +: DW]
//   pwm_out   out  PWM outputs, one per channel
//   wrap      out  one-cycle pulse marking period start
//   dbg_state out  press FSM state (0 = IDLE, 1 = HOLD)
module pwm_gen_multi #(
  parameter int             CH        = 4,
  parameter int             DW        = 4,
  parameter int             TW        = 6,
  parameter logic [TW-1:0]  T_SHORT   = 6'd20,
  parameter logic [TW-1:0]  T_LONG    = 6'd30,
  parameter int             PRE       = 1,
  parameter logic [DW-1:0]  DUTY_INIT = '0,
  localparam int            SW        = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SW-1:0]    sel,
  output logic [CH*DW-1:0] d_c,
  output logic [CH-1:0]    pwm_out,
  output logic             wrap,
  output logic             dbg_state
);

  localparam int            PW       = (PRE > 1) ? $clog2(PRE) : 1;
  localparam logic [DW-1:0] MAXD     = {DW{1'b1}};
  // Last counter value before the wrap back to 0 (period = MAXD steps).
  localparam logic [DW-1:0] CNT_LAST = DW'((1 << DW) - 2);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRE - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t        state_q;
  logic [TW-1:0] hold_cnt_q;
  logic [DW-1:0] duty_q [CH];
  logic [DW-1:0] act_q  [CH];

  logic [PW-1:0] pre_q, pre_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          wrap_q, wrap_d;
  logic          tick;

  // ---------------------------------------------------------------------
  // Press FSM: measures the hold time and applies the duty change on the
  // release edge. hold_cnt saturates at T_LONG so any longer hold still
  // classifies as long without overflowing.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      hold_cnt_q <= '0;
      for (int i = 0; i < CH; i++) begin
        duty_q[i] <= DUTY_INIT;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_HOLD;
            hold_cnt_q <= TW'(1);
          end
        end
        S_HOLD: begin
          if (start) begin
            if (hold_cnt_q < T_LONG) begin
              hold_cnt_q <= hold_cnt_q + TW'(1);
            end
          end else begin
            state_q    <= S_IDLE;
            hold_cnt_q <= '0;
            // An out-of-range sel matches no channel, so the press is dropped.
            for (int i = 0; i < CH; i++) begin
              if (int'(sel) == i) begin
                if (hold_cnt_q >= T_LONG) begin
                  if (duty_q[i] != '0) begin
                    duty_q[i] <= duty_q[i] - DW'(1);
                  end
                end else if (hold_cnt_q >= T_SHORT) begin
                  if (duty_q[i] != MAXD) begin
                    duty_q[i] <= duty_q[i] + DW'(1);
                  end
                end
              end
            end
          end
        end
        default: begin
          state_q    <= S_IDLE;
          hold_cnt_q <= '0;
        end
      endcase
    end
  end

  assign dbg_state = state_q;

  // ---------------------------------------------------------------------
  // Prescaler and period counter.
  // ---------------------------------------------------------------------
  assign tick = (pre_q == PRE_LAST);

  always_comb begin
    pre_d  = tick ? '0 : pre_q + PW'(1);
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (tick) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        wrap_d = 1'b1;
      end else begin
        cnt_d = cnt_q + DW'(1);
      end
    end
  end

  // act loads on the wrap edge from the current duty_q, so a press that is
  // evaluated on that same edge only shows up one period later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q  <= '0;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        act_q[i] <= '0;
      end
    end else begin
      pre_q  <= pre_d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      if (wrap_d) begin
        for (int i = 0; i < CH; i++) begin
          act_q[i] <= duty_q[i];
        end
      end
    end
  end

  assign wrap = wrap_q;

  // Outputs depend only on registered cnt/act, so they cannot glitch on
  // duty updates.
  always_comb begin
    pwm_out = '0;
    d_c     = '0;
    for (int i = 0; i < CH; i++) begin
      pwm_out[i]       = (cnt_q < act_q[i]);
      d_c[i*DW +: DW]  = duty_q[i];
    end
  end

endmodule

// File: tb/tb_pwm_gen_multi.sv
// Testbench for pwm_gen_multi (CH=4, DW=4, PRE=1, T_SHORT=20, T_LONG=30).
module tb_pwm_gen_multi;

  localparam int CH     = 4;
  localparam int PERIOD = 15;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [15:0] d_c;
  logic [3:0]  pwm_out;
  logic        wrap;
  logic        dbg_state;

  always #10 clk = ~clk;

  pwm_gen_multi dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sel       (sel),
    .d_c       (d_c),
    .pwm_out   (pwm_out),
    .wrap      (wrap),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q[$];
  bit          chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Time since reset release is a cycle count; the counter position is that
  // count modulo the period, and every multiple of the period is a wrap.
  int m_duty [CH];
  int m_act  [CH];
  int m_cyc;
  int m_len;
  bit m_wrap;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CH; i++) begin
        m_duty[i] = 0;
        m_act[i]  = 0;
      end
      m_cyc  = 0;
      m_len  = 0;
      m_wrap = 0;
    end else begin
      m_cyc++;
      m_wrap = (m_cyc % PERIOD == 0);
      if (m_wrap) begin
        for (int i = 0; i < CH; i++) m_act[i] = m_duty[i];
      end
      if (start) begin
        m_len++;
      end else if (m_len > 0) begin
        if (int'(sel) < CH) begin
          if (m_len >= 30)      m_duty[sel] = (m_duty[sel] > 0)  ? m_duty[sel] - 1 : 0;
          else if (m_len >= 20) m_duty[sel] = (m_duty[sel] < 15) ? m_duty[sel] + 1 : 15;
        end
        m_len = 0;
      end
    end
  end

  function automatic logic [15:0] model_dc();
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < CH; i++) v[i*4 +: 4] = m_duty[i][3:0];
    return v;
  endfunction

  function automatic logic [3:0] model_pwm();
    logic [3:0] v;
    v = '0;
    for (int i = 0; i < CH; i++) v[i] = ((m_cyc % PERIOD) < m_act[i]);
    return v;
  endfunction

  // Continuous cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_dc",   32'(d_c),     32'(model_dc()));
      check("cyc_pwm",  32'(pwm_out), 32'(model_pwm()));
      check("cyc_wrap", 32'(wrap),    32'(m_wrap));
    end
  end

  // ---------------- driver tasks ----------------
  // Press: start is sampled high on exactly len edges, then released; returns
  // at the negedge right after the evaluation edge.
  task automatic press(input logic [1:0] s, input int len);
    sel   = s;
    start = 1'b1;
    repeat (len) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits for a wrap (bounded), then counts high cycles of one channel over
  // one full period.
  task automatic count_high(input int ch, input string name, output int highs);
    int n;
    n = 0;
    highs = 0;
    while (!wrap && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!wrap) begin
      check({name, "_wrap_timeout"}, 32'(0), 32'(1));
    end else begin
      for (int k = 0; k < PERIOD; k++) begin
        highs += int'(pwm_out[ch]);
        @(negedge clk);
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  sel;
    int          len;
    logic [15:0] exp_dc;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int n;
    int h;

    vecs[0] = '{2'd0, 25, 16'h0001};  // short press
    vecs[1] = '{2'd0, 10, 16'h0001};  // glitch
    vecs[2] = '{2'd2, 40, 16'h0001};  // long at duty 0 saturates
    vecs[3] = '{2'd3, 20, 16'h1001};  // exactly T_SHORT
    vecs[4] = '{2'd3, 19, 16'h1001};  // one below T_SHORT
    vecs[5] = '{2'd3, 30, 16'h0001};  // exactly T_LONG
    vecs[6] = '{2'd2, 29, 16'h0101};  // one below T_LONG is short

    // Reset check
    #24;
    check("rst_dc",   32'(d_c),     32'h0);
    check("rst_pwm",  32'(pwm_out), 32'h0);
    check("rst_wrap", 32'(wrap),    32'h0);
    rst = 1'b1;
    chk_en = 1'b1;

    n = 0;
    while (!wrap && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("first_wrap_clocks", 32'(n), 32'd15);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!wrap && n < 40);
    check("wrap_interval", 32'(n), 32'd15);
    @(negedge clk);
    check("wrap_one_cycle", 32'(wrap), 32'h0);

    // Table-driven presses
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(vecs[i].exp_dc);
      press(vecs[i].sel, vecs[i].len);
      check($sformatf("vec%0d_dc", i), 32'(d_c), 32'(exp_q.pop_front()));
    end

    count_high(0, "duty1", h);
    check("duty1_highs", 32'(h), 32'd1);

    // Saturation high on channel 1
    for (int i = 0; i < 16; i++) begin
      press(2'd1, 22);
      idle(1);
    end
    check("sat_hi_dc", 32'(d_c), 32'h01F1);
    count_high(1, "sat_hi", h);
    check("sat_hi_highs", 32'(h), 32'd15);
    press(2'd1, 35);
    check("long_dc", 32'(d_c), 32'h01E1);

    // Boundary: evaluation on the same edge as a wrap tick
    n = 0;
    while (!wrap && n < 40) begin
      @(negedge clk);
      n++;
    end
    idle(7);
    press(2'd0, 22);
    check("bnd_wrap", 32'(wrap), 32'h1);
    check("bnd_dc",   32'(d_c),  32'h01E2);
    h = 0;
    for (int k = 0; k < PERIOD; k++) begin
      h += int'(pwm_out[0]);
      @(negedge clk);
    end
    check("bnd_first_period", 32'(h), 32'd1);
    h = 0;
    for (int k = 0; k < PERIOD; k++) begin
      h += int'(pwm_out[0]);
      @(negedge clk);
    end
    check("bnd_second_period", 32'(h), 32'd2);

    // Randomized presses checked by the model
    for (int i = 0; i < 30; i++) begin
      press(2'($urandom_range(0, 3)), $urandom_range(1, 45));
      idle($urandom_range(0, 5));
    end
    check("rand_dc", 32'(d_c), 32'(model_dc()));

    // Reset mid-press
    sel   = 2'd0;
    start = 1'b1;
    idle(15);
    #5 rst = 1'b0;
    #1;
    check("midrst_dc",   32'(d_c),       32'h0);
    check("midrst_fsm",  32'(dbg_state), 32'h0);
    check("midrst_wrap", 32'(wrap),      32'h0);
    @(negedge clk);
    @(negedge clk);
    #5 rst = 1'b1;
    idle(10);
    start = 1'b0;
    idle(3);
    check("midrst_after_dc", 32'(d_c), 32'h0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pwm_gen_multi.md
# pwm_gen_multi

Multi-channel PWM generator with press-duration duty control. A single `start` input is classified per press as short (duty up), long (duty down) or glitch (ignored), and the result is applied to the channel chosen by `sel`. A shared prescaled period counter drives `CH` glitch-free PWM outputs whose duty codes are double-buffered and take effect only at period boundaries. This block is the parametrised successor of the single-channel PWM generator and sits between the user-input conditioning logic and the output drivers.

## Interface
- `CH`, 4: number of PWM channels (≥1).
- `DW`, 4: duty code width; period is `MAXD = 2^DW-1` counter steps.
- `TW`, 6: press-counter width.
- `T_SHORT`, 6'd20: minimum hold cycles for a valid short press.
- `T_LONG`, 6'd30: minimum hold cycles for a long press; `T_LONG > T_SHORT`, and `T_LONG < 2^TW`.
- `PRE`, 1: clocks per counter step (≥1).
- `DUTY_INIT`, 0: reset duty code of every channel.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: press input, already synchronous to `clk`.
- `sel` in max(1,$clog2(CH)): target channel, sampled at press evaluation.
- `d_c` out CH*DW: programmed duty codes, channel i at `[i*DW +: DW]`.
- `pwm_out` out CH: PWM outputs.
- `wrap` out 1: one-cycle pulse marking period start.

## Operation
- Press FSM states: IDLE, HOLD.
  - IDLE→HOLD when `start`=1 is sampled. `hold_cnt` is then 1.
  - In HOLD, `hold_cnt` increments each cycle `start`=1 and saturates at `T_LONG`.
  - HOLD→IDLE when `start`=0 is sampled. At that same edge, evaluate with H=`hold_cnt`:
    - If H ≥ `T_LONG`: `d_c[sel]` decrements, saturating at 0.
    - Else if H ≥ `T_SHORT`: `d_c[sel]` increments, saturating at `MAXD`.
    - Else: no change.
  - `hold_cnt` is cleared on return to IDLE.
- `sel` ≥ CH at evaluation: the press is ignored.
- A long hold is not applied until release. An indefinitely held `start` causes no update.
- Period counter:
  - The prescaler produces `tick` every `PRE` clocks.
  - On `tick`, `cnt` advances 0..MAXD-1 and wraps to 0.
  - On the wrap tick, `act[i] <= d_c[i]` for all channels and `wrap` pulses for that one cycle.
- `pwm_out[i] = (cnt < act[i])`, evaluated from registered `cnt`/`act` only.
  - Duty 0 gives constant low.
  - Duty `MAXD` gives constant high.
  - Duty k gives k high steps per period.
- Simultaneous press evaluation and wrap: the wrap loads the pre-update `d_c`. The new value is applied at the next wrap.

## Timing
- Reset (`rst`=0, asynchronous) takes effect immediately:
  - `d_c` = `DUTY_INIT` on all channels.
  - `act` = 0, `cnt` = 0, prescaler = 0, `hold_cnt` = 0, FSM = IDLE.
  - `pwm_out` = 0, `wrap` = 0.
- Reset mid-press discards the press. Counting restarts from the first `start`=1 sampled after release of reset.
- `d_c` updates on the same edge at which `start`=0 is first sampled after a press, so the latency is 0 cycles after the release sample.
- Duty-change-to-output latency runs until the next wrap tick, at most `MAXD*PRE` clocks.
- With `PRE`=1:
  - The period is 15 clocks for DW=4.
  - The first wrap after reset is 15 clocks after reset release.
  - `wrap` is high exactly 1 clock per period.

## Test plan
Unless stated otherwise, all scenarios use CH=4, DW=4, PRE=1, T_SHORT=20, T_LONG=30 and a 20 ns clock.
- Reset check: hold `rst`=0 for 24 ns → `d_c`=16'h0000, `pwm_out`=0, `wrap`=0. Release reset → `wrap` pulses every 15 clocks.
- Short press: `sel`=0, `start` high for 25 clocks → `d_c[3:0]`=1 at release. After the next `wrap`, `pwm_out[0]` is high 1 of every 15 clocks, and `act` is unchanged before that wrap.
- Glitch and long press: `start` high for 10 clocks → `d_c` unchanged. `sel`=2, `start` high for 40 clocks at duty 0 → `d_c[11:8]` stays 0 (saturation).
- Saturation high: `sel`=1, 16 short presses of 22 clocks each → `d_c[7:4]`=15. From the following wrap, `pwm_out[1]` is constantly 1. One long press of 35 clocks → 14.
- Boundary: release a short press so that evaluation coincides with the wrap tick → the new duty appears at the second wrap, not the first.
- Reset mid-press: `start` high for 15 clocks, assert `rst` for 2 clocks, then `start` high for 10 more clocks → no duty change. `d_c` stays at `DUTY_INIT`.
